// File: rtl/radix2_bf_pkg.sv
// Shared defaults and arithmetic helpers for the radix-2 butterfly core.
// Helpers work on 64-bit signed values; callers narrow the result.
package radix2_bf_pkg;

  localparam int DEF_IN_W     = 8;
  localparam int DEF_IN_FRAC  = 5;
  localparam int DEF_TW_W     = 8;
  localparam int DEF_TW_FRAC  = 5;
  localparam int DEF_OUT_W    = 10;
  localparam int DEF_OUT_FRAC = 5;

  // Half-LSB constant used for round-half-up before dropping 'frac' bits.
  function automatic logic signed [63:0] rnd_half(input int unsigned frac);
    return (frac == 0) ? 64'sd0 : (64'sd1 <<< (frac - 1));
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                 input int unsigned w,
                                                 output logic hit);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    hit = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/bf_cmult.sv
// Full-precision complex multiply W*B with optional conj(W); owns the S1 product register.
module bf_cmult
  import radix2_bf_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int TW_W = DEF_TW_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic signed [IN_W-1:0]        b_re,
  input  logic signed [IN_W-1:0]        b_im,
  input  logic signed [TW_W-1:0]        w_re,
  input  logic signed [TW_W-1:0]        w_im,
  input  logic                          inverse,
  output logic signed [IN_W+TW_W:0]     p_re,
  output logic signed [IN_W+TW_W:0]     p_im
);

  localparam int PW = IN_W + TW_W + 1;

  // One extra bit so negating the most negative w_im stays exact.
  logic signed [TW_W:0] wi_ext;
  logic signed [TW_W:0] wi_eff;
  logic signed [PW-1:0] br, bi, wr, wi;
  logic signed [PW-1:0] re_d, im_d;

  always_comb begin
    wi_ext = (TW_W + 1)'(w_im);
    wi_eff = inverse ? -wi_ext : wi_ext;
    br     = PW'(b_re);
    bi     = PW'(b_im);
    wr     = PW'(w_re);
    wi     = PW'(wi_eff);
    re_d   = br * wr - bi * wi;
    im_d   = br * wi + bi * wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_re <= '0;
      p_im <= '0;
    end else if (en) begin
      p_re <= re_d;
      p_im <= im_d;
    end
  end

endmodule

// File: rtl/radix2_butterfly_core.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B with rounding,
// optional halving, output alignment, saturation and a sticky overflow flag.
module radix2_butterfly_core
  import radix2_bf_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int TW_W     = DEF_TW_W,
  parameter int TW_FRAC  = DEF_TW_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_FRAC = DEF_OUT_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  a_re,
  input  logic signed [IN_W-1:0]  a_im,
  input  logic signed [IN_W-1:0]  b_re,
  input  logic signed [IN_W-1:0]  b_im,
  input  logic signed [TW_W-1:0]  w_re,
  input  logic signed [TW_W-1:0]  w_im,
  input  logic                    inverse,
  input  logic                    scale,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] x_re,
  output logic signed [OUT_W-1:0] x_im,
  output logic signed [OUT_W-1:0] y_re,
  output logic signed [OUT_W-1:0] y_im,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int PW = IN_W + TW_W + 1;  // full product width
  localparam int RW = PW - TW_FRAC;     // W*B rounded to IN_FRAC fraction bits
  localparam int SW = RW + 1;           // guard bit for the add/sub

  logic advance;
  logic out_valid_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // ---------------- S1: complex multiply ----------------
  logic                   v1_q, scale1_q;
  logic signed [IN_W-1:0] a1_q [2];
  logic signed [PW-1:0]   p_re, p_im;

  bf_cmult #(
    .IN_W (IN_W),
    .TW_W (TW_W)
  ) u_cmult (
    .clk     (clk),
    .rst     (rst),
    .en      (advance && in_valid),
    .b_re    (b_re),
    .b_im    (b_im),
    .w_re    (w_re),
    .w_im    (w_im),
    .inverse (inverse),
    .p_re    (p_re),
    .p_im    (p_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      scale1_q <= 1'b0;
      a1_q[0]  <= '0;
      a1_q[1]  <= '0;
    end else if (advance) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q[0]  <= a_re;
        a1_q[1]  <= a_im;
        scale1_q <= scale;
      end
    end
  end

  // ---------------- S2: round W*B, add/sub ----------------
  logic signed [PW:0]   rr_re, rr_im;
  logic signed [RW-1:0] wb_re, wb_im;
  logic signed [SW-1:0] s2_d [4];
  logic signed [SW-1:0] s2_q [4];
  logic                 v2_q, scale2_q;

  always_comb begin
    rr_re   = (PW + 1)'(p_re) + (PW + 1)'(rnd_half(TW_FRAC));
    rr_im   = (PW + 1)'(p_im) + (PW + 1)'(rnd_half(TW_FRAC));
    wb_re   = RW'(rr_re >>> TW_FRAC);
    wb_im   = RW'(rr_im >>> TW_FRAC);
    s2_d[0] = SW'(a1_q[0]) + SW'(wb_re);
    s2_d[1] = SW'(a1_q[1]) + SW'(wb_im);
    s2_d[2] = SW'(a1_q[0]) - SW'(wb_re);
    s2_d[3] = SW'(a1_q[1]) - SW'(wb_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q     <= 1'b0;
      scale2_q <= 1'b0;
      for (int i = 0; i < 4; i++) s2_q[i] <= '0;
    end else if (advance) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q     <= s2_d;
        scale2_q <= scale1_q;
      end
    end
  end

  // ---------------- S3: scale, align, saturate ----------------
  logic signed [OUT_W-1:0] o_d [4];
  logic signed [OUT_W-1:0] o_q [4];
  logic [3:0]              hit;
  logic signed [63:0]      t3;
  logic                    h3;
  logic                    ovf_d, ovf_q;

  always_comb begin
    t3  = '0;
    h3  = 1'b0;
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      t3 = 64'(s2_q[i]);
      if (scale2_q) t3 = (t3 + 64'sd1) >>> 1;
      if (OUT_FRAC < IN_FRAC) begin
        t3 = (t3 + rnd_half(IN_FRAC - OUT_FRAC)) >>> (IN_FRAC - OUT_FRAC);
      end else if (OUT_FRAC > IN_FRAC) begin
        t3 = t3 <<< (OUT_FRAC - IN_FRAC);
      end
      t3     = sat_val(t3, OUT_W, h3);
      hit[i] = h3;
      o_d[i] = OUT_W'(t3);
    end
  end

  // Saturation is flagged when the offending sample is loaded into the output register.
  always_comb begin
    ovf_d = ovf_q;
    if (advance && v2_q && (|hit)) ovf_d = 1'b1;
    else if (ovf_clr)              ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < 4; i++) o_q[i] <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (advance) begin
        out_valid_q <= v2_q;
        if (v2_q) o_q <= o_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign x_re      = o_q[0];
  assign x_im      = o_q[1];
  assign y_re      = o_q[2];
  assign y_im      = o_q[3];

endmodule

// File: doc/radix2_butterfly_core.md
RADIX2_BUTTERFLY_CORE -- requirements
Module: radix2_butterfly_core

Interface
REQ-001 Parameter IN_W, default 8, meaning data input word width (two's complement).
REQ-002 Parameter IN_FRAC, default 5, meaning input fractional bits.
REQ-003 Parameter TW_W, default 8, meaning twiddle word width.
REQ-004 Parameter TW_FRAC, default 5, meaning twiddle fractional bits.
REQ-005 Parameter OUT_W, default 10, meaning output word width.
REQ-006 Parameter OUT_FRAC, default 5, meaning output fractional bits (OUT_FRAC <= IN_FRAC+1).
REQ-007 Port clk, input, 1, meaning the single clock (rising edge).
REQ-008 Port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-009 Port in_valid / in_ready, input / output, 1 each, meaning input handshake.
REQ-010 Port a_re, a_im, b_re, b_im, input, IN_W each, meaning operands A and B.
REQ-011 Port w_re, w_im, input, TW_W each, meaning twiddle W, sampled with the operands.
REQ-012 Port inverse, input, 1, meaning use conj(W) (IFFT), sampled with the operands.
REQ-013 Port scale, input, 1, meaning halve both results (per-stage scaling), sampled with the operands.
REQ-014 Port out_valid / out_ready, output / input, 1 each, meaning output handshake.
REQ-015 Port x_re, x_im, y_re, y_im, output, OUT_W each, meaning X = A + W*B and Y = A - W*B.
REQ-016 Port ovf, output, 1, meaning sticky saturation flag.
REQ-017 Port ovf_clr, input, 1, meaning synchronous clear of ovf.

Function
REQ-018 A transfer occurs on a clk edge where in_valid && in_ready; an output is consumed where out_valid && out_ready.
REQ-019 The datapath SHALL be a 3-stage pipeline: S1 complex multiply, S2 round and add/sub, S3 scale/align/saturate; latency is 3 cycles with no stall.
REQ-020 Pipeline advance SHALL be advance = !out_valid || out_ready; in_ready = advance, combinationally; with a permanently high out_ready, throughput is 1 per cycle.
REQ-021 While advance is low, every stage register and out_valid SHALL hold; outputs SHALL stay stable while out_valid && !out_ready.
REQ-022 Per-stage valid bits SHALL track bubbles; out_valid is the S3 valid bit.
REQ-023 S1: the product SHALL use full precision (IN_W+TW_W+1 bits per component); when inverse = 1, w_im is negated before the multiply.
REQ-024 S2: W*B SHALL be rounded to IN_FRAC fractional bits, round-half-up (add 2^(TW_FRAC-1), then arithmetic shift); X and Y SHALL carry at least one guard bit so the add cannot wrap.
REQ-025 S3: when scale = 1, results SHALL be shifted right by 1 with round-half-up; then aligned to OUT_FRAC, rounding half-up when bits are dropped.
REQ-026 S3: each component SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-027 Any saturation in a transferred output SHALL set ovf on that cycle; ovf stays set until ovf_clr; if both occur on the same cycle, set wins.
REQ-028 inverse and scale SHALL travel with their operand set, so a per-sample mode change needs no pipeline drain.

Reset
REQ-029 While rst is high: all valid bits, out_valid and ovf = 0; x/y outputs = 0; in_ready = 1.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight samples; the first out_valid after reset release comes from a post-release input.

Structure
REQ-031 A shared package radix2_bf_pkg SHALL hold default widths, the rounding-constant function and the saturation function.
REQ-032 The complex multiplier SHALL be one sub-module, bf_cmult (S1 register included).

Verification
REQ-033 W=1+0j (w_re=32), A=(51,-45), B=(37,-56), scale=0 -> after 3 cycles X=(88,-101), Y=(14,11), ovf=0.
REQ-034 W=0+0.5j (w_im=16), same A and B -> W*B imag 18.5 LSB rounds to 19; X=(79,-26), Y=(23,-64).
REQ-035 W=-4+0j (w_re=-128), A=(127,0), B=(-128,0) -> X_re saturates to 511, Y_re=-385, ovf=1; ovf_clr clears it.
REQ-036 Back-to-back stream of 8 samples with out_ready toggling every cycle -> no loss or duplication, held outputs stable, in_ready equals !out_valid || out_ready.
REQ-037 REQ-033 vectors with inverse=1 and W=0+1j, then scale=1 -> conjugate result observed, then halved results rounded half-up.
REQ-038 rst pulsed with 2 samples in flight -> out_valid=0 immediately, no stale output after release.
